mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. A small FSM grants one requester at a time and holds the RAM handshake until acknowledge. It returns data and a one-cycle ready pulse, and drives per-stage stall lines to the hazard unit. Starvation guard and ack-timeout make it robust against a slow or hung memory model.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
STARVE_LIMIT, 4, consecutive MEM grants with IF pending before IF is forced
TIMEOUT, 15, cycles waiting for ram_ack before abort (counter width = clog2(TIMEOUT+1))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid with if_ready
if_ready  out  1  one-cycle completion pulse to IF
if_stall  out  1  IF must hold PC
mem_rd_req  in  1  load request, held until mem_ready
mem_wr_req  in  1  store request, held until mem_ready
mem_addr  in  ADDR_W  load/store address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, valid with mem_ready
mem_ready  out  1  one-cycle completion pulse to MEM
mem_stall  out  1  MEM (and upstream stages) must hold
ram_en  out  1  RAM access strobe, held until ram_ack
ram_we  out  1  1 = write
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid with ram_ack
ram_ack  in  1  RAM completion, one-cycle pulse
bus_err  out  1  sticky: a timeout occurred

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; starve and timeout counters 0; bus_err cleared. Reset asserted mid-access abandons it; no ready pulse is issued.
- States: IDLE, GRANT_IF, GRANT_MEM.
- IDLE: arbitrate on the sampled requests. mem_req = mem_rd_req | mem_wr_req.
  - MEM wins if mem_req, unless if_req and starve_cnt == STARVE_LIMIT.
  - Otherwise IF wins if if_req.
  - On a grant, register ram_addr, ram_we, ram_wdata; ram_en=1 from the next cycle.
- A mem_wr_req and mem_rd_req asserted together is treated as a write.
- GRANT_x: hold ram_en and all ram_* outputs stable until ram_ack.
  - On the ram_ack cycle, register ram_rdata into x_rdata (writes leave mem_rdata unchanged).
  - Next cycle: pulse x_ready=1 and ram_en=0, and return to IDLE.
  - Arbitration may regrant in that same IDLE cycle, so back-to-back accesses are ram_en low for exactly 1 cycle.
- Minimum latency: request at cycle 0, ram_en at 1, ram_ack at 1, x_ready at 2.
- ram_ack while in IDLE is ignored.
- Starvation counter:
  - increments on each MEM grant while if_req=1, saturating at STARVE_LIMIT;
  - clears on an IF grant or whenever if_req=0 in IDLE.
- Timeout:
  - the counter clears on entry to GRANT_x and increments each cycle without ram_ack;
  - on reaching TIMEOUT: drop ram_en, pulse x_ready with x_rdata=0, set bus_err, go to IDLE.
  - bus_err clears only on reset.
- Stalls (combinational): if_stall = if_req & ~if_ready; mem_stall = mem_req & ~mem_ready.
- A requester dropping its request mid-grant is a protocol violation. The transaction still completes and the ready pulse is still issued.

Decomposition:
- Shared package mips_pkg: arb_state_t enum (IDLE, GRANT_IF, GRANT_MEM); ADDR_W/DATA_W defaults.
- One natural sub-module, arb_timeout_cnt: a clear/enable counter with a terminal flag, reused for the watchdog.
- Starvation counter stays inline.

Test Plan:
- Reset and fetch: reset low 2 cycles, then release. if_req=1, if_addr=0x0000_0040; RAM acks 1 cycle after ram_en with 0x2008_0005 -> ram_we=0, ram_addr=0x40; if_ready pulse with if_rdata=0x2008_0005; if_stall high until that pulse.
- Simultaneous requests: if_req and mem_wr_req (addr 0x100, wdata 0xDEAD_BEEF) in the same cycle -> MEM granted first with ram_we=1 and ram_wdata=0xDEAD_BEEF; IF granted next, after a 1-cycle ram_en gap.
- Starvation: MEM requests continuously with if_req held -> IF granted after exactly 4 MEM grants; starve count then restarts.
- Timeout: grant IF and never assert ram_ack -> after 15 cycles ram_en=0, if_ready=1, if_rdata=0, bus_err=1 (stays 1 until reset).
- Reset mid-access: assert reset while in GRANT_MEM with ram_en=1 -> ram_en drops asynchronously; no mem_ready pulse; after release the first request is served normally.
- Read plus write collision: mem_rd_req and mem_wr_req both 1 -> ram_we=1; mem_rdata unchanged after mem_ready.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline types: memory-arbiter state encoding and default bus widths.
package mips_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IF  = 2'd1,
        GRANT_MEM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Clear/enable up-counter; done flags the LIMIT-th consecutive enabled cycle.
module arb_timeout_cnt #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != W'(LIMIT))
            cnt <= cnt + 1'b1;
    end

    // Fires during the cycle that completes LIMIT waiting cycles, so the owner can abort on that edge.
    assign done = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store, with
// starvation guard for fetch and an ack watchdog that aborts hung accesses.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_cnt;
    logic          mem_req, if_force, busy, fin, to_done;
    logic          grant_if, grant_mem;

    assign mem_req   = mem_rd_req | mem_wr_req;
    assign if_force  = if_req && (starve_cnt == SW'(STARVE_LIMIT));
    assign busy      = (state_q != IDLE);
    assign fin       = busy && (ram_ack || to_done);
    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = mem_req & ~mem_ready;

    arb_timeout_cnt #(.LIMIT(TIMEOUT)) u_wdog (
        .clk  (clk),
        .reset(reset),
        .clr  (!busy),
        .en   (busy && !ram_ack),
        .done (to_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_req && !if_force) begin
                    grant_mem = 1'b1;
                    state_d   = GRANT_MEM;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_d  = GRANT_IF;
                end
            end
            GRANT_IF, GRANT_MEM: if (fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            bus_err    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;

            // Simultaneous read+write requests resolve to a write.
            if (grant_mem) begin
                ram_en    <= 1'b1;
                ram_we    <= mem_wr_req;
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
            end else if (grant_if) begin
                ram_en   <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= if_addr;
            end

            // Completion or watchdog abort; an abort returns zero data and latches bus_err.
            if (fin) begin
                ram_en <= 1'b0;
                if (!ram_ack)
                    bus_err <= 1'b1;
                if (state_q == GRANT_IF) begin
                    if_ready <= 1'b1;
                    if_rdata <= ram_ack ? ram_rdata : '0;
                end else begin
                    mem_ready <= 1'b1;
                    if (!ram_ack)
                        mem_rdata <= '0;
                    else if (!ram_we)
                        mem_rdata <= ram_rdata;
                end
            end

            if (grant_mem && if_req) begin
                if (starve_cnt != SW'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_if || (!busy && !if_req)) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected RAM
// accesses and responses; a monitor pops and compares as the DUT presents them.
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ram_exp_t;

    logic        clk, reset;
    logic        if_req, if_ready, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        mem_rd_req, mem_wr_req, mem_ready, mem_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        ram_en, ram_we, ram_ack, bus_err;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_if[$];
    logic [31:0] exp_mem[$];
    ram_exp_t    exp_ram[$];
    logic [31:0] ram_model[logic [31:0]];

    bit   ack_on  = 1'b1;
    int   ack_dly = 0;
    int   wcnt    = 0;
    logic ram_en_q = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM model: acks ack_dly negedges after ram_en is first seen.
    always @(negedge clk) begin
        if (ram_ack) begin
            ram_ack = 1'b0;
            wcnt    = 0;
        end else if (ram_en && ack_on) begin
            if (wcnt >= ack_dly) begin
                if (ram_we) ram_model[ram_addr] = ram_wdata;
                ram_rdata = ram_model.exists(ram_addr) ? ram_model[ram_addr] : 32'h0;
                ram_ack   = 1'b1;
                wcnt      = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        ram_exp_t e;
        logic [31:0] d;
        if (ram_en && !ram_en_q) begin
            if (exp_ram.size() == 0) begin
                chk("unexpected_ram_en", 32'(ram_en), 32'h0);
            end else begin
                e = exp_ram.pop_front();
                chk("ram_we", 32'(ram_we), 32'(e.we));
                chk("ram_addr", ram_addr, e.addr);
                if (e.we) chk("ram_wdata", ram_wdata, e.wdata);
            end
        end
        ram_en_q = ram_en;
        if (if_ready) begin
            if (exp_if.size() == 0) chk("unexpected_if_ready", 32'(if_ready), 32'h0);
            else begin d = exp_if.pop_front(); chk("if_rdata", if_rdata, d); end
        end
        if (mem_ready) begin
            if (exp_mem.size() == 0) chk("unexpected_mem_ready", 32'(mem_ready), 32'h0);
            else begin d = exp_mem.pop_front(); chk("mem_rdata", mem_rdata, d); end
        end
    end

    task automatic do_if(input logic [31:0] a, output int cyc);
        bit got = 1'b0;
        cyc     = 0;
        if_req  = 1'b1;
        if_addr = a;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (if_ready) begin
                got = 1'b1;
                cyc = n;
                chk("if_stall_at_ready", 32'(if_stall), 32'h0);
            end else begin
                chk("if_stall_wait", 32'(if_stall), 32'h1);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL if_ready_timeout: got none expected pulse within 40 cycles");
        end
        if_req = 1'b0;
    endtask

    task automatic do_mem(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, output int cyc);
        bit got = 1'b0;
        cyc        = 0;
        mem_rd_req = rd;
        mem_wr_req = wr;
        mem_addr   = a;
        mem_wdata  = wd;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (mem_ready) begin
                got = 1'b1;
                cyc = n;
                chk("mem_stall_at_ready", 32'(mem_stall), 32'h0);
            end else begin
                chk("mem_stall_wait", 32'(mem_stall), 32'h1);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL mem_ready_timeout: got none expected pulse within 40 cycles");
        end
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2;
        reset = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_rd_req = 1'b0; mem_wr_req = 1'b0; mem_addr = '0; mem_wdata = '0;
        ram_ack = 1'b0; ram_rdata = '0;
        ram_model[32'h40]  = 32'h2008_0005;
        ram_model[32'h44]  = 32'h8C01_0004;
        ram_model[32'h200] = 32'h1111_0000;
        ram_model[32'h204] = 32'h2222_0000;
        for (int i = 0; i < 9; i++) ram_model[32'h300 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);

        repeat (2) @(negedge clk);
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_if_ready", 32'(if_ready), 32'h0);
        chk("rst_mem_ready", 32'(mem_ready), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_stalls", {30'h0, if_stall, mem_stall}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Fetch with RAM acking one cycle after ram_en
        ack_dly = 1;
        exp_ram.push_back('{1'b0, 32'h40, 32'h0});
        exp_if.push_back(32'h2008_0005);
        do_if(32'h40, c1);
        chk("fetch_latency", 32'(c1), 32'd3);
        ack_dly = 0;

        // Simultaneous: MEM write first, IF after a one-cycle ram_en gap
        exp_ram.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF});
        exp_ram.push_back('{1'b0, 32'h44, 32'h0});
        exp_mem.push_back(32'h0);
        exp_if.push_back(32'h8C01_0004);
        fork
            do_mem(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, c1);
            do_if(32'h44, c2);
        join
        chk("simul_mem_latency", 32'(c1), 32'd2);
        chk("simul_if_latency", 32'(c2), 32'd4);

        // Starvation: IF forced after 4 MEM grants, then the count restarts
        for (int i = 0; i < 4; i++) exp_ram.push_back('{1'b0, 32'h300 + 32'(4 * i), 32'h0});
        exp_ram.push_back('{1'b0, 32'h200, 32'h0});
        for (int i = 4; i < 8; i++) exp_ram.push_back('{1'b0, 32'h300 + 32'(4 * i), 32'h0});
        exp_ram.push_back('{1'b0, 32'h204, 32'h0});
        exp_ram.push_back('{1'b0, 32'h320, 32'h0});
        for (int i = 0; i < 9; i++) exp_mem.push_back(32'hA000_0000 + 32'(i));
        exp_if.push_back(32'h1111_0000);
        exp_if.push_back(32'h2222_0000);
        fork
            begin
                int cm;
                for (int i = 0; i < 9; i++) do_mem(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, cm);
            end
            begin
                do_if(32'h200, c1);
                do_if(32'h204, c2);
            end
        join
        chk("starve_if1_wait", 32'(c1), 32'd10);
        chk("starve_if2_wait", 32'(c2), 32'd10);

        // Timeout: no ack -> abort after 15 cycles of ram_en
        ack_on = 1'b0;
        exp_ram.push_back('{1'b0, 32'h48, 32'h0});
        exp_if.push_back(32'h0);
        do_if(32'h48, c1);
        chk("timeout_latency", 32'(c1), 32'd16);
        chk("timeout_ram_en", 32'(ram_en), 32'h0);
        chk("timeout_bus_err", 32'(bus_err), 32'h1);
        ack_on = 1'b1;
        exp_ram.push_back('{1'b0, 32'h40, 32'h0});
        exp_if.push_back(32'h2008_0005);
        do_if(32'h40, c1);
        chk("bus_err_sticky", 32'(bus_err), 32'h1);

        // Reset in the middle of a MEM access
        ack_on = 1'b0;
        exp_ram.push_back('{1'b0, 32'h100, 32'h0});
        mem_rd_req = 1'b1;
        mem_addr   = 32'h100;
        repeat (3) @(negedge clk);
        chk("midrst_ram_en_before", 32'(ram_en), 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_ram_en_async", 32'(ram_en), 32'h0);
        chk("midrst_bus_err", 32'(bus_err), 32'h0);
        mem_rd_req = 1'b0;
        ack_on     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_ram.push_back('{1'b0, 32'h100, 32'h0});
        exp_mem.push_back(32'hDEAD_BEEF);
        do_mem(1'b1, 1'b0, 32'h100, 32'h0, c1);
        chk("post_rst_latency", 32'(c1), 32'd2);

        // Read+write collision is a write; mem_rdata holds
        exp_ram.push_back('{1'b1, 32'h104, 32'h1234_5678});
        exp_mem.push_back(32'hDEAD_BEEF);
        do_mem(1'b1, 1'b1, 32'h104, 32'h1234_5678, c1);
        exp_ram.push_back('{1'b0, 32'h104, 32'h0});
        exp_mem.push_back(32'h1234_5678);
        do_mem(1'b1, 1'b0, 32'h104, 32'h0, c1);

        repeat (4) @(negedge clk);
        chk("left_exp_ram", 32'(exp_ram.size()), 32'h0);
        chk("left_exp_if", 32'(exp_if.size()), 32'h0);
        chk("left_exp_mem", 32'(exp_mem.size()), 32'h0);
        chk("final_bus_err", 32'(bus_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
